// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, frame shifted out on the device clock,
// acknowledge check. Only the open-drain enables are driven here; the pads live at top level.

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 6000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int BIT_TIMEOUT_CYCLES   = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAX_ALL = (MAX_AB > BIT_TIMEOUT_CYCLES) ? MAX_AB : BIT_TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQUEST,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]       r_bitcnt, w_bitcnt_nxt;
    logic [8:0]       r_frame;
    logic             r_clk_meta, r_clk_sync, r_clk_prev;
    logic             r_data_meta, r_data_sync;
    logic             w_fall, w_accept;

    // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk_in;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_in;
            r_data_sync <= r_data_meta;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync;
    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bitcnt <= w_bitcnt_nxt;
        end
    end

    // NOTE: no reset on the frame register; it is loaded on every accepted command before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_frame <= {~^cmd_data, cmd_data};
        end else if (r_state == S_SHIFT && w_fall) begin
            r_frame <= {1'b1, r_frame[8:1]};
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_cnt_nxt    = w_cnt_inc;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt    = '0;
                w_bitcnt_nxt = '0;
                if (cmd_valid) w_state_nxt = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (r_cnt == INH_LAST) begin
                    w_state_nxt = S_REQUEST;
                    w_cnt_nxt   = '0;
                end
            end
            // A fall restarts the window at 1: the fall cycle itself is the first elapsed cycle.
            S_REQUEST: begin
                if (w_fall) begin
                    w_state_nxt  = S_SHIFT;
                    w_bitcnt_nxt = 4'd1;
                    w_cnt_nxt    = CNT_W'(1);
                end else if (r_cnt == START_LAST) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_SHIFT: begin
                if (w_fall) begin
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    w_cnt_nxt    = CNT_W'(1);
                    if (r_bitcnt == 4'd9) w_state_nxt = S_ACK;
                end else if (r_cnt == BIT_LAST) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ACK: begin
                if (w_fall) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = r_data_sync ? S_ERR : S_WAIT_IDLE;
                end else if (r_cnt == BIT_LAST) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_sync && r_data_sync) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == BIT_LAST) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The start bit goes out in the last inhibit cycle; ACK onwards leaves data released (stop bit).
    always_comb begin
        ps2_data_oe = 1'b0;
        unique case (r_state)
            S_INHIBIT: ps2_data_oe = (r_cnt == INH_LAST);
            S_REQUEST: ps2_data_oe = 1'b1;
            S_SHIFT:   ps2_data_oe = ~r_frame[0];
            default:   ps2_data_oe = 1'b0;
        endcase
    end

    assign ps2_clk_oe = (r_state == S_INHIBIT);
    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign tx_done    = (r_state == S_DONE);
    assign tx_error   = (r_state == S_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain bus model plus a behavioural PS/2 device
// that clocks frames, samples data on rising edges and acknowledges (or not).
`timescale 1ns/1ps

module tb_ps2_host_tx;

    localparam int INH      = 100;
    localparam int START_TO = 500;
    localparam int BIT_TO   = 300;
    localparam int H        = 40;   // device half period in system clocks (scaled-down PS/2 clock)

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       cmd_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
    logic       bus_clk, bus_data;

    assign bus_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign bus_data = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES       (INH),
        .START_TIMEOUT_CYCLES (START_TO),
        .BIT_TIMEOUT_CYCLES   (BIT_TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .ps2_clk_in  (bus_clk),
        .ps2_data_in (bus_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   run = 0, inh_len = 0, n_inh = 0, n_done = 0, n_txerr = 0;
    int   bad_both = 0, bad_doe = 0, rel_cyc = 0, err_cyc = 0;
    logic inh_tail_doe = 1'b0, prev_clk_oe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_clk_oe <= ps2_clk_oe;
        if (ps2_clk_oe) begin
            run          <= run + 1;
            inh_tail_doe <= ps2_data_oe;
            if (!prev_clk_oe) n_inh <= n_inh + 1;
        end else if (prev_clk_oe) begin
            inh_len <= run;
            rel_cyc <= cyc;
            run     <= 0;
        end
        if (tx_done) n_done <= n_done + 1;
        if (tx_error) begin
            n_txerr <= n_txerr + 1;
            err_cyc <= cyc;
        end
        if (tx_done && tx_error) bad_both <= bad_both + 1;
        if ((cmd_ready || tx_done || tx_error) && ps2_data_oe) bad_doe <= bad_doe + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(negedge clk);
        check({tag, "_ready_in_time"}, 32'(got), 32'd1);
    endtask

    // Device: waits for the request (clock released, data low), then issues n_falls clock
    // pulses. bits[0] is the start bit; bits[k] is what the device sees at rising edge k.
    task automatic dev_frame(input int n_falls, input bit ack, output logic [10:0] bits,
                             output int last_fall_cyc, output bit ok);
        ok = 1'b0;
        bits = '0;
        last_fall_cyc = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus_clk && !bus_data) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        bits[0] = bus_data;
        repeat (H) @(negedge clk);
        for (int k = 1; k <= n_falls; k++) begin
            if (k == 11) begin
                dev_data_low = ack;
                repeat (5) @(negedge clk);
            end
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (H) @(negedge clk);
            if (k <= 10) bits[k] = bus_data;
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            repeat (H) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        int          lf;
        bit          ok;
        int          d0, e0, i0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_tx_error", 32'(tx_error), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED acknowledged: frame {stop 1, parity 1, ED, start 0} = 0x7DA
        d0 = n_done; e0 = n_txerr;
        send(8'hED);
        check("ed_busy", 32'(busy), 32'd1);
        check("ed_cmd_ready_low", 32'(cmd_ready), 32'd0);
        dev_frame(11, 1'b1, bits, lf, ok);
        check("ed_request_seen", 32'(ok), 32'd1);
        wait_ready("ed", 500);
        check("ed_inhibit_len", 32'(inh_len), 32'(INH));
        check("ed_start_bit_in_last_inhibit", 32'(inh_tail_doe), 32'd1);
        check("ed_frame", 32'(bits), 32'h7DA);
        check("ed_done_pulses", 32'(n_done - d0), 32'd1);
        check("ed_error_pulses", 32'(n_txerr - e0), 32'd0);

        // 0xF4 acknowledged: parity 0, frame 0x5E8
        d0 = n_done;
        send(8'hF4);
        dev_frame(11, 1'b1, bits, lf, ok);
        wait_ready("f4", 500);
        check("f4_frame", 32'(bits), 32'h5E8);
        check("f4_done_pulses", 32'(n_done - d0), 32'd1);

        // 0xFF with NACK: frame 0x7FE, error pulse, no done, lines released
        d0 = n_done; e0 = n_txerr;
        send(8'hFF);
        dev_frame(11, 1'b0, bits, lf, ok);
        wait_ready("ff", 500);
        check("ff_frame", 32'(bits), 32'h7FE);
        check("ff_error_pulses", 32'(n_txerr - e0), 32'd1);
        check("ff_done_pulses", 32'(n_done - d0), 32'd0);
        check("ff_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("ff_data_oe", 32'(ps2_data_oe), 32'd0);

        // Device never clocks: error exactly START_TO cycles after clock release
        d0 = n_done; e0 = n_txerr;
        send(8'h55);
        wait_ready("start_to", 2000);
        check("start_to_latency", 32'(err_cyc - rel_cyc), 32'(START_TO));
        check("start_to_error_pulses", 32'(n_txerr - e0), 32'd1);
        check("start_to_done_pulses", 32'(n_done - d0), 32'd0);
        check("start_to_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("start_to_data_oe", 32'(ps2_data_oe), 32'd0);

        // Device stops after 5 falls (d4 on the line). The host sees a pad edge driven at a
        // negedge as a fall pulse two cycles later, so the error lands BIT_TO + 2 after the drive.
        e0 = n_txerr;
        send(8'h3C);
        dev_frame(5, 1'b1, bits, lf, ok);
        wait_ready("bit_to", 1000);
        check("bit_to_partial_bits", 32'(bits[5:0]), 32'h38);
        check("bit_to_latency", 32'(err_cyc - lf), 32'(BIT_TO + 2));
        check("bit_to_error_pulses", 32'(n_txerr - e0), 32'd1);

        // Recovery: 0x01 with parity 0, frame 0x402
        d0 = n_done;
        send(8'h01);
        dev_frame(11, 1'b1, bits, lf, ok);
        wait_ready("x01", 500);
        check("x01_frame", 32'(bits), 32'h402);
        check("x01_done_pulses", 32'(n_done - d0), 32'd1);

        // cmd_valid pulses while busy are ignored: one frame (0x96, frame 0x72C) only
        d0 = n_done; i0 = n_inh;
        send(8'h96);
        repeat (10) @(negedge clk);
        cmd_data = 8'h00; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        dev_frame(11, 1'b1, bits, lf, ok);
        wait_ready("x96", 500);
        repeat (200) @(negedge clk);
        check("x96_frame", 32'(bits), 32'h72C);
        check("x96_single_inhibit", 32'(n_inh - i0), 32'd1);
        check("x96_done_pulses", 32'(n_done - d0), 32'd1);

        // Reset mid-SHIFT at bitcnt 5: 0xA5 has d4 = 0, so data is being driven low
        d0 = n_done; e0 = n_txerr;
        send(8'hA5);
        dev_frame(5, 1'b1, bits, lf, ok);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_d4_driven", 32'(ps2_data_oe), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_tx_done", 32'(tx_done), 32'd0);
        check("mid_rst_tx_error", 32'(tx_error), 32'd0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (400) @(negedge clk);
        check("mid_rst_no_done", 32'(n_done - d0), 32'd0);
        check("mid_rst_no_error", 32'(n_txerr - e0), 32'd0);
        check("mid_rst_idle", 32'(cmd_ready), 32'd1);

        // Whole-run invariants
        check("never_done_and_error", 32'(bad_both), 32'd0);
        check("data_oe_low_when_idle", 32'(bad_doe), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
